clk_div_seq: RTL and testbench

Glitch-safe reconfiguration sequencer for the system clock divider. It accepts divide-select and divide-enable requests from the clock/reset control register file. It drives the divider's `div_sel` and `div_en` inputs one field at a time, waiting a fixed settle interval after every change so each clock mux completes its switchover. A `hold` output quiesces downstream logic for the whole sequence.

---
 rtl/clk_div_seq_pkg.sv | 28 ++
 rtl/clk_seq_timer.sv | 35 +++
 rtl/clk_div_seq.sv | 136 +++++++++++++
 tb/tb_clk_div_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_seq_pkg.sv
// Shared definitions for the clock-divider reconfiguration sequencer.
// The divide-select codes are also used by the register file and the divider itself.
package clk_div_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_STEP    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_FINISH  = 3'd4
  } seq_state_e;

  localparam logic [1:0] DIV_2  = 2'b00;
  localparam logic [1:0] DIV_4  = 2'b01;
  localparam logic [1:0] DIV_8  = 2'b10;
  localparam logic [1:0] DIV_16 = 2'b11;

  localparam logic [1:0] DIV_SEL_RST = DIV_2;
  localparam logic       DIV_EN_RST  = 1'b0;

  // The counter only ever holds cycles-1, so log2 of the larger wait is enough.
  function automatic int cnt_width(input int hold_cycles, input int settle_cycles);
    int m;
    m = (hold_cycles > settle_cycles) ? hold_cycles : settle_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clk_seq_timer.sv
// Loadable down-counter with zero flag; shared by the quiesce and settle waits.
// Decrement saturates at zero so a stray dec can never wrap into a long wait.
module clk_seq_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_div_seq.sv
// Glitch-safe divider reconfiguration: changes div_en/div_sel one field at a time,
// waiting a settle interval after each change while hold quiesces downstream logic.
module clk_div_seq
  import clk_div_seq_pkg::*;
#(
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  input  logic       req_en,
  output logic       req_ready,
  output logic       done,
  output logic       busy,
  output logic       hold,
  output logic [1:0] div_sel,
  output logic       div_en
);

  localparam int            CW          = cnt_width(HOLD_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  seq_state_e    state_d, state_q;
  logic [1:0]    tgt_sel_d, tgt_sel_q;
  logic          tgt_en_d, tgt_en_q;
  logic [1:0]    div_sel_d, div_sel_q;
  logic          div_en_d, div_en_q;
  logic          hold_d, hold_q;
  logic          done_d, done_q;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0] tmr_load_val;

  always_comb begin
    state_d      = state_q;
    tgt_sel_d    = tgt_sel_q;
    tgt_en_d     = tgt_en_q;
    div_sel_d    = div_sel_q;
    div_en_d     = div_en_q;
    hold_d       = hold_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tgt_sel_d = req_sel;
          tgt_en_d  = req_en;
          if ((req_sel == div_sel_q) && (req_en == div_en_q)) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_QUIESCE;
            hold_d       = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LOAD;
          end
        end
      end
      ST_QUIESCE: begin
        if (tmr_zero) state_d = ST_STEP;
      end
      ST_STEP: begin
        state_d      = ST_SETTLE;
        tmr_load     = 1'b1;
        tmr_load_val = SETTLE_LOAD;
        // The select may only move while the divider path is bypassed.
        if (div_en_q && (div_sel_q != tgt_sel_q)) begin
          div_en_d = 1'b0;
        end else if (div_sel_q != tgt_sel_q) begin
          div_sel_d = tgt_sel_q;
        end else if (div_en_q != tgt_en_q) begin
          div_en_d = tgt_en_q;
        end else begin
          state_d  = ST_FINISH;
          tmr_load = 1'b0;
          hold_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) state_d = ST_STEP;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tgt_sel_q <= DIV_SEL_RST;
      tgt_en_q  <= DIV_EN_RST;
      div_sel_q <= DIV_SEL_RST;
      div_en_q  <= DIV_EN_RST;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_sel_q <= tgt_sel_d;
      tgt_en_q  <= tgt_en_d;
      div_sel_q <= div_sel_d;
      div_en_q  <= div_en_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
    end
  end

  assign tmr_dec = (state_q == ST_QUIESCE) || (state_q == ST_SETTLE);

  clk_seq_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clki     (clki),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign hold      = hold_q;
  assign done      = done_q;
  assign div_sel   = div_sel_q;
  assign div_en    = div_en_q;

endmodule

// File: tb/tb_clk_div_seq.sv
// Scoreboard bench for clk_div_seq: the driver pushes the expected outcome of each
// accepted request, a monitor pops and checks it whenever done pulses.
module tb_clk_div_seq;

  localparam int HOLD   = 2;
  localparam int SETTLE = 8;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_en;
  logic       req_ready;
  logic       done;
  logic       busy;
  logic       hold;
  logic [1:0] div_sel;
  logic       div_en;

  clk_div_seq #(
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clki      (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_en    (req_en),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .hold      (hold),
    .div_sel   (div_sel),
    .div_en    (div_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              acc;
    int              lat;
    int              n;
    logic [1:0]      sel;
    logic            en;
    logic [2:0][2:0] seq;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] m_sel;
  logic       m_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: the list of divider configurations visited on the way to the target.
  function automatic exp_t build_exp(input logic [1:0] s, input logic e);
    exp_t       x;
    logic [1:0] cs;
    logic       ce;
    cs    = m_sel;
    ce    = m_en;
    x.n   = 0;
    x.seq = '0;
    x.sel = s;
    x.en  = e;
    x.acc = cyc;
    if (ce && (cs != s)) begin ce = 1'b0; x.seq[x.n] = {cs, ce}; x.n++; end
    if (cs != s)         begin cs = s;    x.seq[x.n] = {cs, ce}; x.n++; end
    if (ce != e)         begin ce = e;    x.seq[x.n] = {cs, ce}; x.n++; end
    x.lat = (x.n == 0) ? 1 : HOLD + x.n * (SETTLE + 1) + 2;
    return x;
  endfunction

  task automatic monitor();
    exp_t       x;
    logic [1:0] ps;
    logic       pe;
    int         hold_cnt;
    int         ccyc[$];
    logic [2:0] cval[$];
    int         m;
    ps       = div_sel;
    pe       = div_en;
    hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        ccyc.delete();
        cval.delete();
        hold_cnt = 0;
      end else begin
        if ({div_sel, div_en} != {ps, pe}) begin
          chk("sel_moved_with_en", 32'((div_sel != ps) && (pe || div_en)), 0);
          ccyc.push_back(cyc);
          cval.push_back({div_sel, div_en});
        end
        if (hold) hold_cnt++;
        if (done) begin
          chk("done_expected", 32'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("done_latency", 32'(cyc - x.acc), 32'(x.lat));
            chk("final_cfg", 32'({div_sel, div_en}), 32'({x.sel, x.en}));
            chk("hold_at_done", 32'(hold), 0);
            chk("n_changes", 32'(ccyc.size()), 32'(x.n));
            chk("hold_cycles", 32'(hold_cnt), 32'((x.n == 0) ? 0 : x.lat - 1));
            m = (ccyc.size() < x.n) ? ccyc.size() : x.n;
            for (int i = 0; i < m; i++) begin
              chk("change_time", 32'(ccyc[i] - x.acc), 32'(HOLD + 2 + i * (SETTLE + 1)));
              chk("change_value", 32'(cval[i]), 32'(x.seq[i]));
            end
          end
          ccyc.delete();
          cval.delete();
          hold_cnt = 0;
        end
      end
      ps = div_sel;
      pe = div_en;
    end
  endtask

  task automatic issue(input logic [1:0] s, input logic e, input bit poke,
                       input logic [1:0] ps, input logic pe);
    exp_t x;
    int   pk;
    x = build_exp(s, e);
    sb_q.push_back(x);
    req_valid = 1'b1;
    req_sel   = s;
    req_en    = e;
    tick();
    req_valid = 1'b0;
    req_sel   = 2'($urandom);
    req_en    = 1'($urandom);
    m_sel     = s;
    m_en      = e;
    pk = (poke && x.lat > 2) ? int'($urandom_range(x.lat - 1, 1)) : 0;
    for (int i = 1; i < x.lat; i++) begin
      if (i == pk) begin
        req_valid = 1'b1;
        req_sel   = ps;
        req_en    = pe;
      end
      tick();
      req_valid = 1'b0;
    end
    chk("busy_at_done", 32'({req_ready, busy}), 32'(2'b01));
    tick();
    chk("done_seen", 32'(sb_q.size()), 0);
    sb_q.delete();
    chk("idle_after_done", 32'({req_ready, busy, done, hold}), 32'(4'b1000));
  endtask

  task automatic reset_mid(input logic [1:0] s, input logic e);
    exp_t x;
    x = build_exp(s, e);
    sb_q.push_back(x);
    req_valid = 1'b1;
    req_sel   = s;
    req_en    = e;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    chk("mid_seq_state", 32'({busy, hold, div_sel, div_en}), 32'({2'b11, x.seq[0]}));
    rst = 1'b1;
    tick();
    chk("reset_mid_seq", 32'({div_sel, div_en, hold, busy, req_ready, done}), 32'(7'b0000010));
    rst   = 1'b0;
    m_sel = 2'b00;
    m_en  = 1'b0;
    repeat (40) tick();
    chk("no_done_after_reset", 32'({done, hold, busy}), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = 2'b00;
    req_en    = 1'b0;
    m_sel     = 2'b00;
    m_en      = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_idle", 32'({div_sel, div_en, req_ready, hold, busy, done}), 32'(6'b001000));
    end

    issue(2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
    issue(2'b01, 1'b1, 1'b0, 2'b00, 1'b0);
    issue(2'b01, 1'b1, 1'b0, 2'b00, 1'b0);
    issue(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);
    issue(2'b10, 1'b1, 1'b1, 2'b11, 1'b0);
    reset_mid(2'b01, 1'b1);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
